// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
// Holds the FSM state encodings and the state-width constant.
// No logic; imported by hazard_unit and hazard_cmp.
package hazard_pkg;

  localparam int STATE_W = 2;

  // Encoding 3 is never entered; the FSM returns to RUN from it.
  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use detector: a load in EX whose destination is read by the ID instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the hazard FSM.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    load_use_o = ex_is_load_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory-wait stall, taken-branch flush, load-use bubble.
// Latency: outputs are combinational from state, counters and current inputs.
// Backpressure: stall_o freezes IF/ID/EX; memory stall outranks flush outranks load-use.
// Optional HAZARD_STALL_CNT_EN: saturating count of stalled cycles on stall_cnt_o.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [4:0]         id_rs1_i,
  input  logic [4:0]         id_rs2_i,
  input  logic               id_uses_rs1_i,
  input  logic               id_uses_rs2_i,
  input  logic               ex_is_load_i,
  input  logic [4:0]         ex_rd_i,
  input  logic               mem_req_i,
  input  logic               mem_ack_i,
  input  logic               branch_taken_i,
  output logic               stall_o,
  output logic               bubble_o,
  output logic               flush_o,
  output logic               mem_err_o,
  output logic [STATE_W-1:0] state_o,
  output logic [31:0]        stall_cnt_o
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [8:0] TO_LIMIT   = 9'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] mem_cnt_q, mem_cnt_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic [8:0] mem_cnt_inc;
  logic       load_use;
  logic       mem_miss;
  logic       stall, bubble, flush, mem_err;

  hazard_cmp u_cmp (
    .ex_is_load_i  (ex_is_load_i),
    .ex_rd_i       (ex_rd_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .load_use_o    (load_use)
  );

  // State and counter registers; reset aborts any wait or flush in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_cnt_q   <= mem_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and hazard outputs. The wait count includes the current
  // cycle, so the timeout fires on MEM_WAIT cycle MEM_TIMEOUT-1; an ack
  // in that same cycle wins over the timeout.
  always_comb begin
    state_d     = state_q;
    mem_cnt_d   = mem_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall       = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    mem_err     = 1'b0;
    mem_miss    = mem_req_i && !mem_ack_i;
    mem_cnt_inc = {1'b0, mem_cnt_q} + 9'd1;
    case (state_q)
      RUN: begin
        if (mem_miss) begin
          stall     = 1'b1;
          state_d   = MEM_WAIT;
          mem_cnt_d = '0;
        end else if (branch_taken_i) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = RUN;
        end else if (mem_cnt_inc >= TO_LIMIT) begin
          mem_err = 1'b1;
          state_d = RUN;
        end else begin
          stall     = 1'b1;
          mem_cnt_d = mem_cnt_inc[7:0];
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (mem_miss) begin
          stall = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Input-driven terms are masked so every output reads 0 while reset is held.
  assign stall_o   = rst_ni && stall;
  assign bubble_o  = rst_ni && bubble;
  assign flush_o   = rst_ni && flush;
  assign mem_err_o = rst_ni && mem_err;
  assign state_o   = state_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
// Stall-count checks are active only when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_uses_rs1_i, id_uses_rs2_i, ex_is_load_i;
  logic        mem_req_i, mem_ack_i, branch_taken_i;
  logic        stall_o, bubble_o, flush_o, mem_err_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  hazard_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_uses_rs1_i  (id_uses_rs1_i),
    .id_uses_rs2_i  (id_uses_rs2_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_rd_i        (ex_rd_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .branch_taken_i (branch_taken_i),
    .stall_o        (stall_o),
    .bubble_o       (bubble_o),
    .flush_o        (flush_o),
    .mem_err_o      (mem_err_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; ex_is_load_i = 1'b0;
    mem_req_i = 1'b0; mem_ack_i = 1'b0; branch_taken_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_load_use();
    ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_uses_rs1_i = 1'b1;
  endtask

  initial begin
    // Reset with every hazard input active: outputs must all read 0.
    idle();
    rst_ni = 1'b0;
    set_load_use();
    mem_req_i = 1'b1;
    branch_taken_i = 1'b1;
    @(negedge clk_i);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_bubble", 32'(bubble_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_err", 32'(mem_err_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_cnt", stall_cnt_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    idle();

    // Miss for 3 cycles then ack: stall 3 cycles, low on ack.
    mem_req_i = 1'b1;
    @(negedge clk_i); chk("mw_c1_stall", 32'(stall_o), 32'd1); chk("mw_c1_state", 32'(state_o), 32'd0);
    tick(); @(negedge clk_i); chk("mw_c2_stall", 32'(stall_o), 32'd1); chk("mw_c2_state", 32'(state_o), 32'd1);
    tick(); @(negedge clk_i); chk("mw_c3_stall", 32'(stall_o), 32'd1); chk("mw_c3_state", 32'(state_o), 32'd1);
    tick(); mem_ack_i = 1'b1;
    @(negedge clk_i); chk("mw_ack_stall", 32'(stall_o), 32'd0); chk("mw_ack_err", 32'(mem_err_o), 32'd0);
    chk("mw_ack_state", 32'(state_o), 32'd1);
    tick(); idle();
    @(negedge clk_i); chk("mw_done_state", 32'(state_o), 32'd0); chk("mw_done_stall", 32'(stall_o), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("mw_stall_cnt", stall_cnt_o, 32'd3);
`endif

    // Load-use on rs1, then gone next cycle.
    tick(); set_load_use();
    @(negedge clk_i); chk("lu_stall", 32'(stall_o), 32'd1); chk("lu_bubble", 32'(bubble_o), 32'd1);
    chk("lu_state", 32'(state_o), 32'd0);
    tick(); idle();
    @(negedge clk_i); chk("lu_next_stall", 32'(stall_o), 32'd0); chk("lu_next_bubble", 32'(bubble_o), 32'd0);
    // Load to x0 never stalls.
    tick(); ex_is_load_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_uses_rs1_i = 1'b1;
    @(negedge clk_i); chk("lu_x0_stall", 32'(stall_o), 32'd0);
    // Match through rs2.
    tick(); ex_rd_i = 5'd7; id_rs1_i = 5'd3; id_rs2_i = 5'd7; id_uses_rs2_i = 1'b1;
    @(negedge clk_i); chk("lu_rs2_bubble", 32'(bubble_o), 32'd1);
    // Same register but rs2 not read.
    tick(); id_uses_rs2_i = 1'b0;
    @(negedge clk_i); chk("lu_unused_stall", 32'(stall_o), 32'd0);

    // Timeout with MEM_TIMEOUT=4: stall 3 cycles, error pulse on cycle 4.
    tick(); idle(); mem_req_i = 1'b1;
    @(negedge clk_i); chk("to_c1_stall", 32'(stall_o), 32'd1); chk("to_c1_err", 32'(mem_err_o), 32'd0);
    tick(); @(negedge clk_i); chk("to_c2_stall", 32'(stall_o), 32'd1); chk("to_c2_err", 32'(mem_err_o), 32'd0);
    tick(); @(negedge clk_i); chk("to_c3_stall", 32'(stall_o), 32'd1); chk("to_c3_err", 32'(mem_err_o), 32'd0);
    tick(); @(negedge clk_i); chk("to_c4_stall", 32'(stall_o), 32'd0); chk("to_c4_err", 32'(mem_err_o), 32'd1);
    chk("to_c4_state", 32'(state_o), 32'd1);
    tick(); idle();
    @(negedge clk_i); chk("to_done_state", 32'(state_o), 32'd0); chk("to_done_err", 32'(mem_err_o), 32'd0);

    // Branch coincident with load-use: flush 2 cycles, no bubble.
    tick(); set_load_use(); branch_taken_i = 1'b1;
    @(negedge clk_i); chk("br_c1_flush", 32'(flush_o), 32'd1); chk("br_c1_bubble", 32'(bubble_o), 32'd0);
    chk("br_c1_stall", 32'(stall_o), 32'd0);
    tick(); branch_taken_i = 1'b0;
    @(negedge clk_i); chk("br_c2_flush", 32'(flush_o), 32'd1); chk("br_c2_bubble", 32'(bubble_o), 32'd0);
    chk("br_c2_state", 32'(state_o), 32'd2);
    tick(); idle();
    @(negedge clk_i); chk("br_done_flush", 32'(flush_o), 32'd0); chk("br_done_state", 32'(state_o), 32'd0);

    // Memory miss during FLUSH freezes the flush counter.
    tick(); branch_taken_i = 1'b1;
    @(negedge clk_i); chk("fm_c1_flush", 32'(flush_o), 32'd1);
    tick(); branch_taken_i = 1'b0; mem_req_i = 1'b1;
    @(negedge clk_i); chk("fm_c2_stall", 32'(stall_o), 32'd1); chk("fm_c2_flush", 32'(flush_o), 32'd1);
    tick(); mem_req_i = 1'b0;
    @(negedge clk_i); chk("fm_c3_state", 32'(state_o), 32'd2); chk("fm_c3_flush", 32'(flush_o), 32'd1);
    chk("fm_c3_stall", 32'(stall_o), 32'd0);
    tick(); @(negedge clk_i); chk("fm_done_state", 32'(state_o), 32'd0); chk("fm_done_flush", 32'(flush_o), 32'd0);

    // Memory stall outranks a branch.
    tick(); mem_req_i = 1'b1; branch_taken_i = 1'b1;
    @(negedge clk_i); chk("pr_stall", 32'(stall_o), 32'd1); chk("pr_flush", 32'(flush_o), 32'd0);
    tick(); mem_ack_i = 1'b1;
    @(negedge clk_i); chk("pr_mw_state", 32'(state_o), 32'd1); chk("pr_mw_flush", 32'(flush_o), 32'd0);
    chk("pr_mw_stall", 32'(stall_o), 32'd0);
    tick(); idle();
    @(negedge clk_i); chk("pr_done_state", 32'(state_o), 32'd0);

    // Ack in the same cycle as the request: no stall at all.
    tick(); mem_req_i = 1'b1; mem_ack_i = 1'b1;
    @(negedge clk_i); chk("hit_stall", 32'(stall_o), 32'd0);
    tick(); @(negedge clk_i); chk("hit_state", 32'(state_o), 32'd0);

    // Reset during MEM_WAIT cycle 2: immediate abort, no error pulse.
    tick(); idle(); mem_req_i = 1'b1;
    tick();
    tick();
    #2;
    chk("ar_pre_state", 32'(state_o), 32'd1);
    chk("ar_pre_stall", 32'(stall_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("ar_stall", 32'(stall_o), 32'd0);
    chk("ar_bubble", 32'(bubble_o), 32'd0);
    chk("ar_flush", 32'(flush_o), 32'd0);
    chk("ar_err", 32'(mem_err_o), 32'd0);
    chk("ar_state", 32'(state_o), 32'd0);
    chk("ar_cnt", stall_cnt_o, 32'd0);
    tick(); mem_req_i = 1'b0; rst_ni = 1'b1;
    @(negedge clk_i); chk("ar_post_err", 32'(mem_err_o), 32'd0); chk("ar_post_state", 32'(state_o), 32'd0);
    tick(); @(negedge clk_i); chk("ar_post2_err", 32'(mem_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
